thwomp_spawner: RTL and testbench

//  Read side of the Thwomp X-coordinate FIFO. Runs in the 25 MHz pixel-clock domain.

---
 rtl/thwomp_spawner_pkg.sv | 24 ++
 rtl/thwomp_spawner_frame_timer.sv | 28 ++
 rtl/thwomp_spawner.sv | 139 +++++++++++++
 tb/tb_thwomp_spawner.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/thwomp_spawner_pkg.sv
// Shared sprite geometry defaults and coordinate helpers for the Thwomp hazard.
// Geometry here must stay in step with the PRNG and the sprite renderers.
package thwomp_spawner_pkg;

  localparam int COORD_W = 10;
  localparam int CNT_W   = 8;   // frame counters hold up to 256 ticks

  localparam int DEF_H_DISP       = 640;
  localparam int DEF_FLOOR        = 450;
  localparam int DEF_T_WIDTH      = 24;
  localparam int DEF_T_HEIGHT     = 32;
  localparam int DEF_Y_START      = 0;
  localparam int DEF_FALL_STEP    = 4;
  localparam int DEF_HOVER_FRAMES = 30;
  localparam int DEF_LAND_FRAMES  = 60;

  typedef logic [COORD_W-1:0] coord_t;

  // A 10-bit word never exceeds twice the limit, so a single subtraction is a full modulo.
  function automatic coord_t foldX(input coord_t d, input coord_t lim);
    return (d > lim) ? coord_t'(d - lim) : d;
  endfunction

endpackage

// File: rtl/thwomp_spawner_frame_timer.sv
// Tick-driven frame counter with synchronous clear and runtime terminal count.
// done is combinational: high on the counted tick that reaches the limit; counter wraps to 0 then.
module thwomp_spawner_frame_timer
  import thwomp_spawner_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign done = en && (cnt == limit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/thwomp_spawner.sv
// Thwomp life-cycle sequencer: pops a random X from the FIFO, hovers, falls, rests, repeats.
// Read data arrives one cycle after o_rden; all outputs except o_stall are registered.
module thwomp_spawner
  import thwomp_spawner_pkg::*;
#(
  parameter int H_DISP       = DEF_H_DISP,
  parameter int FLOOR        = DEF_FLOOR,
  parameter int T_WIDTH      = DEF_T_WIDTH,
  parameter int T_HEIGHT     = DEF_T_HEIGHT,
  parameter int Y_START      = DEF_Y_START,
  parameter int FALL_STEP    = DEF_FALL_STEP,
  parameter int HOVER_FRAMES = DEF_HOVER_FRAMES,
  parameter int LAND_FRAMES  = DEF_LAND_FRAMES
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_enable,
  input  logic   i_frame_tick,
  input  logic   i_empty,
  input  coord_t i_rddata,
  output logic   o_rden,
  output coord_t o_x,
  output coord_t o_y,
  output logic   o_active,
  output logic   o_landed,
  output logic   o_stall
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] HOVER   = 3'd3;
  localparam logic [2:0] FALL    = 3'd4;
  localparam logic [2:0] LANDED  = 3'd5;

  localparam coord_t           X_MAX     = coord_t'(H_DISP - T_WIDTH);
  localparam coord_t           Y_LAND    = coord_t'(FLOOR - T_HEIGHT);
  localparam coord_t           Y_SPAWN   = coord_t'(Y_START);
  localparam logic [COORD_W:0] STEP      = (COORD_W+1)'(FALL_STEP);
  localparam logic [CNT_W-1:0] HOV_LAST  = CNT_W'(HOVER_FRAMES - 1);
  localparam logic [CNT_W-1:0] LAND_LAST = CNT_W'(LAND_FRAMES - 1);

  logic [2:0]         state;
  logic               timing;
  logic               timerEn;
  logic               timerClr;
  logic               timerDone;
  logic [CNT_W-1:0]   timerLimit;
  logic [COORD_W:0]   yNext;

  // The timer only counts in HOVER/LANDED; everywhere else it is held at zero so the
  // transition tick into either state is never counted by it.
  assign timing     = (state == HOVER) || (state == LANDED);
  assign timerEn    = timing && i_enable && i_frame_tick;
  assign timerClr   = !timing || !i_enable;
  assign timerLimit = (state == HOVER) ? HOV_LAST : LAND_LAST;
  assign yNext      = {1'b0, o_y} + STEP;
  assign o_stall    = (state == FETCH) && i_empty;

  thwomp_spawner_frame_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timerClr),
    .en    (timerEn),
    .limit (timerLimit),
    .done  (timerDone)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      o_x      <= '0;
      o_y      <= Y_SPAWN;
      o_active <= 1'b0;
      o_rden   <= 1'b0;
      o_landed <= 1'b0;
    end else begin
      o_rden   <= 1'b0;
      o_landed <= 1'b0;
      case (state)
        IDLE: begin
          if (i_enable) state <= FETCH;
        end
        FETCH: begin
          if (!i_enable) begin
            state <= IDLE;
          end else if (!i_empty) begin
            o_rden <= 1'b1;
            state  <= CAPTURE;
          end
        end
        CAPTURE: begin
          o_x <= foldX(i_rddata, X_MAX);
          o_y <= Y_SPAWN;
          if (i_enable) begin
            o_active <= 1'b1;
            state    <= HOVER;
          end else begin
            o_active <= 1'b0;
            state    <= IDLE;
          end
        end
        HOVER: begin
          if (!i_enable) begin
            o_active <= 1'b0;
            state    <= IDLE;
          end else if (timerDone) begin
            state <= FALL;
          end
        end
        FALL: begin
          if (!i_enable) begin
            o_active <= 1'b0;
            state    <= IDLE;
          end else if (i_frame_tick) begin
            if (yNext >= {1'b0, Y_LAND}) begin
              o_y      <= Y_LAND;
              o_landed <= 1'b1;
              state    <= LANDED;
            end else begin
              o_y <= yNext[COORD_W-1:0];
            end
          end
        end
        LANDED: begin
          if (!i_enable) begin
            o_active <= 1'b0;
            state    <= IDLE;
          end else if (timerDone) begin
            o_active <= 1'b0;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_thwomp_spawner.sv
// Directed bench for thwomp_spawner: stall, fold, hover/fall/land timing, disable, async reset.
module tb_thwomp_spawner;

  logic       clk;
  logic       rst;
  logic       i_enable;
  logic       i_frame_tick;
  logic       i_empty;
  logic [9:0] i_rddata;
  logic       o_rden;
  logic [9:0] o_x;
  logic [9:0] o_y;
  logic       o_active;
  logic       o_landed;
  logic       o_stall;

  int nCompared = 0;
  int nMismatched = 0;

  thwomp_spawner #(
    .HOVER_FRAMES (2),
    .LAND_FRAMES  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (i_enable),
    .i_frame_tick (i_frame_tick),
    .i_empty      (i_empty),
    .i_rddata     (i_rddata),
    .o_rden       (o_rden),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_active     (o_active),
    .o_landed     (o_landed),
    .o_stall      (o_stall)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    nCompared++;
    if (obs != exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the edge that registered the tick.
  task automatic tickPulse();
    step();
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
  endtask

  // Precondition: DUT in FETCH. Presents one word and checks the single read pulse.
  task automatic pop(input int word, input bit tickOnCapture);
    int r1, r2;
    i_rddata = 10'(word);
    i_empty  = 1'b0;
    step();
    r1 = int'(o_rden);
    i_empty = 1'b1;
    if (tickOnCapture) i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
    r2 = int'(o_rden);
    chk("rden_pulse", r1, 1);
    chk("rden_single", r2, 0);
  endtask

  int stallLow, rdenHigh, landedSeen;
  int words[5] = '{616, 617, 700, 1023, 0};
  int folded[5] = '{616, 1, 84, 407, 0};

  initial begin
    rst = 1'b0;
    i_enable = 1'b0;
    i_frame_tick = 1'b0;
    i_empty = 1'b1;
    i_rddata = '0;
    repeat (3) step();
    chk("rst_x", int'(o_x), 0);
    chk("rst_y", int'(o_y), 0);
    chk("rst_active", int'(o_active), 0);
    chk("rst_rden", int'(o_rden), 0);
    chk("rst_landed", int'(o_landed), 0);
    chk("rst_stall", int'(o_stall), 0);

    rst = 1'b1;
    i_enable = 1'b1;
    step();

    // Empty stall in FETCH
    stallLow = 0;
    rdenHigh = 0;
    for (int i = 0; i < 20; i++) begin
      if (!o_stall) stallLow++;
      if (o_rden) rdenHigh++;
      step();
    end
    chk("stall_held", stallLow, 0);
    chk("stall_no_rden", rdenHigh, 0);
    pop(100, 1'b0);
    chk("first_x", int'(o_x), 100);
    chk("first_active", int'(o_active), 1);
    chk("first_y", int'(o_y), 0);

    // Disable in HOVER, then re-enable for a new pop
    i_enable = 1'b0;
    step();
    chk("dis_active", int'(o_active), 0);
    chk("dis_x_hold", int'(o_x), 100);
    rdenHigh = 0;
    repeat (3) begin
      if (o_rden) rdenHigh++;
      step();
    end
    chk("dis_no_rden", rdenHigh, 0);
    chk("dis_stall", int'(o_stall), 0);
    i_enable = 1'b1;
    step();
    chk("reen_fetch", int'(o_stall), 1);

    // X fold table, recycling through IDLE between pops
    for (int k = 0; k < 5; k++) begin
      pop(words[k], 1'b0);
      chk($sformatf("fold_%0d", words[k]), int'(o_x), folded[k]);
      i_enable = 1'b0;
      step();
      i_enable = 1'b1;
      step();
    end

    // Tick coincident with CAPTURE is ignored: 2 hover ticks, then the fall starts
    pop(500, 1'b1);
    chk("cap_tick_x", int'(o_x), 500);
    tickPulse();
    chk("hover_t1_y", int'(o_y), 0);
    tickPulse();
    chk("hover_t2_y", int'(o_y), 0);
    tickPulse();
    chk("fall_t1_y", int'(o_y), 4);

    landedSeen = 0;
    for (int i = 0; i < 103; i++) begin
      tickPulse();
      if (o_landed) landedSeen++;
    end
    chk("fall_104_y", int'(o_y), 416);
    chk("fall_no_landed", landedSeen, 0);
    tickPulse();
    chk("land_y", int'(o_y), 418);
    chk("land_pulse", int'(o_landed), 1);
    step();
    chk("land_pulse_end", int'(o_landed), 0);
    chk("land_active", int'(o_active), 1);

    // Rest on the floor for three counted ticks, then fetch again
    tickPulse();
    tickPulse();
    chk("rest_t2_active", int'(o_active), 1);
    chk("rest_t2_stall", int'(o_stall), 0);
    tickPulse();
    chk("rest_done_active", int'(o_active), 0);
    chk("rest_done_y", int'(o_y), 418);
    chk("rest_done_fetch", int'(o_stall), 1);

    // Async reset mid-fall
    pop(300, 1'b0);
    tickPulse();
    tickPulse();
    tickPulse();
    tickPulse();
    chk("pre_rst_y", int'(o_y), 8);
    chk("pre_rst_x", int'(o_x), 300);
    #7;
    rst = 1'b0;
    #1;
    chk("arst_x", int'(o_x), 0);
    chk("arst_y", int'(o_y), 0);
    chk("arst_active", int'(o_active), 0);
    chk("arst_stall", int'(o_stall), 0);
    step();
    step();
    i_rddata = 10'd55;
    i_empty = 1'b0;
    #5;
    rst = 1'b1;
    step();
    chk("post_rst_no_rden", int'(o_rden), 0);
    step();
    chk("post_rst_rden", int'(o_rden), 1);
    i_empty = 1'b1;
    step();
    chk("post_rst_x", int'(o_x), 55);
    chk("post_rst_active", int'(o_active), 1);
    chk("post_rst_rden_once", int'(o_rden), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
